// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: source count, register
// offsets inside the bus window and the "no source" ID value.
package irq_ctrl_pkg;

    localparam int N_SRC = 6;

    localparam logic [4:0] OFF_MASK = 5'h00;
    localparam logic [4:0] OFF_MODE = 5'h04;
    localparam logic [4:0] OFF_PEND = 5'h08;
    localparam logic [4:0] OFF_SET  = 5'h0C;
    localparam logic [4:0] OFF_ID   = 5'h10;

    localparam logic [31:0] ID_NONE = 32'd0;

endpackage

// File: rtl/irq_ctrl_edge_detect.sv
// Per-bit rising-edge detector. During reset the history register loads the
// live inputs, so a line already high when reset drops produces no edge.
module irq_edge_detect #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] prev_q;

    // Loaded unconditionally, reset included.
    always_ff @(posedge clk) begin
        prev_q <= d;
    end

    assign rise = d & ~prev_q & {WIDTH{~reset}};

endmodule

// File: rtl/irq_ctrl.sv
// Bus-mapped interrupt controller: latches edge/level requests, masks them
// and drives the CPU HWInt[7:2] lines; software sees MASK/MODE/PEND/SET/ID.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [31:0]       PrAddr,
    input  logic [31:0]       PrWD,
    input  logic              PrWE,
    output logic [31:0]       PrRD,
    output logic              sel,
    output logic [7:2]        HWInt
);

    logic [N_SRC-1:0] mask_q;
    logic [N_SRC-1:0] mode_q;
    logic [N_SRC-1:0] pend_edge_q;
    logic [N_SRC-1:0] hwint_q;
    logic [N_SRC-1:0] rise;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] active;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] set_sw;
    logic [4:0]       off;
    logic             blk_hit;
    logic             wr_hit;
    logic [31:0]      id;
    logic             unused_wd;

    assign unused_wd = ^PrWD[31:N_SRC];

    irq_edge_detect #(.WIDTH(N_SRC)) u_edge (
        .clk   (clk),
        .reset (reset),
        .d     (irq_in),
        .rise  (rise)
    );

    assign off     = PrAddr[4:0];
    assign blk_hit = (PrAddr[31:5] == BASE_ADDR[31:5]);

    always_comb begin
        sel = 1'b0;
        case (off)
            OFF_MASK, OFF_MODE, OFF_PEND, OFF_SET, OFF_ID: sel = blk_hit;
            default:                                       sel = 1'b0;
        endcase
    end

    assign wr_hit = sel & PrWE;
    assign clr    = (wr_hit && off == OFF_PEND) ? PrWD[N_SRC-1:0] : '0;
    assign set_sw = (wr_hit && off == OFF_SET)  ? PrWD[N_SRC-1:0] : '0;

    // Level sources follow the live line; edge-latched bits are OR'd in for all modes.
    assign pending = pend_edge_q | (~mode_q & irq_in);
    assign active  = pending & mask_q;

    // Scan from the top so the lowest active index is the last to write id.
    always_comb begin
        id = ID_NONE;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) id = 32'(i + 1);
        end
    end

    always_comb begin
        PrRD = '0;
        if (sel) begin
            case (off)
                OFF_MASK: PrRD = 32'(mask_q);
                OFF_MODE: PrRD = 32'(mode_q);
                OFF_PEND: PrRD = 32'(pending);
                OFF_ID:   PrRD = id;
                default:  PrRD = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q      <= '0;
            mode_q      <= '0;
            pend_edge_q <= '0;
            hwint_q     <= '0;
        end else begin
            if (wr_hit && off == OFF_MASK) mask_q <= PrWD[N_SRC-1:0];
            if (wr_hit && off == OFF_MODE) mode_q <= PrWD[N_SRC-1:0];
            // Set terms are OR'd after the clear so a same-cycle edge survives an acknowledge.
            pend_edge_q <= (pend_edge_q & ~clr) | set_sw | (mode_q & rise);
            hwint_q     <= active;
        end
    end

    assign HWInt = hwint_q;

endmodule
